// File: rtl/tag_store_pkg.sv
// Shared types for the victim-cache tag store: entry layout and modify-op priority.
// Optional build macro TAG_STORE_FWD_EN (see tag_store.sv).
package tag_store_pkg;

  // Stored tag width; the top's TAG_WIDTH parameter defaults to this and must match it.
  localparam int unsigned TagWidth = 4;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TagWidth-1:0] tag;
  } tag_entry_t;

  // Modify ops share one way index; a higher encoding wins when several are asserted.
  typedef enum logic [2:0] {
    OpNone       = 3'd0,
    OpDirtyClear = 3'd1,
    OpDirtySet   = 3'd2,
    OpValidClear = 3'd3,
    OpWrite      = 3'd4
  } op_e;

  function automatic op_e decode_op(input logic write_en, input logic valid_clear,
                                    input logic dirty_set, input logic dirty_clear);
    if (write_en) begin
      return OpWrite;
    end else if (valid_clear) begin
      return OpValidClear;
    end else if (dirty_set) begin
      return OpDirtySet;
    end else if (dirty_clear) begin
      return OpDirtyClear;
    end
    return OpNone;
  endfunction

endpackage

// File: rtl/tag_match.sv
// Combinational associative compare of one tag against all ways, with a
// lowest-index priority encoder for the hit way.
module tag_match #(
  parameter int unsigned TAG_WIDTH = 4,
  parameter int unsigned NUM_WAYS  = 4,
  localparam int unsigned IW       = $clog2(NUM_WAYS)
) (
  input  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] tags,
  input  logic [NUM_WAYS-1:0]                valid,
  input  logic [TAG_WIDTH-1:0]               tag_in,
  output logic [NUM_WAYS-1:0]                match,
  output logic                               any_hit,
  output logic [IW-1:0]                      hit_idx
);

  always_comb begin
    match = '0;
    for (int i = 0; i < int'(NUM_WAYS); i++) begin
      match[i] = valid[i] && (tags[i] == tag_in);
    end
  end

  assign any_hit = |match;

  // Scan high to low so the lowest matching way is the last one written.
  always_comb begin
    hit_idx = '0;
    for (int i = int'(NUM_WAYS) - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/tag_store.sv
// Fully associative tag/valid/dirty array for the victim cache.
// Define TAG_STORE_FWD_EN to let same-cycle reads/lookups see the post-update array.
module tag_store
  import tag_store_pkg::*;
#(
  parameter int unsigned TAG_WIDTH = TagWidth,
  parameter int unsigned NUM_WAYS  = 4,
  localparam int unsigned IW       = $clog2(NUM_WAYS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic                 read_en,
  input  logic                 lookup_en,
  input  logic [TAG_WIDTH-1:0] tag_in,
  input  logic [IW-1:0]        way_index_in,
  input  logic                 valid_clear,
  input  logic                 dirty_set,
  input  logic                 dirty_clear,
  output logic                 hit,
  output logic [IW-1:0]        hit_way_index,
  output logic                 valid_read,
  output logic                 dirty_read,
  output logic [TAG_WIDTH-1:0] tag_read
);

  tag_entry_t [NUM_WAYS-1:0] entries_q, entries_d;
  tag_entry_t [NUM_WAYS-1:0] view;
  op_e                       op;

  logic [NUM_WAYS-1:0][TAG_WIDTH-1:0] view_tags;
  logic [NUM_WAYS-1:0]                view_valid;
  logic [NUM_WAYS-1:0]                match_vec;
  logic                               any_hit;
  logic [IW-1:0]                      match_idx;

  logic                 hit_q, hit_d;
  logic [IW-1:0]        hit_idx_q, hit_idx_d;
  logic                 valid_read_q, valid_read_d;
  logic                 dirty_read_q, dirty_read_d;
  logic [TAG_WIDTH-1:0] tag_read_q, tag_read_d;

  assign op = decode_op(write_en, valid_clear, dirty_set, dirty_clear);

  always_comb begin
    entries_d = entries_q;
    case (op)
      OpWrite: begin
        entries_d[way_index_in].tag   = tag_in;
        entries_d[way_index_in].valid = 1'b1;
        entries_d[way_index_in].dirty = 1'b0;
      end
      OpValidClear: begin
        entries_d[way_index_in].valid = 1'b0;
        entries_d[way_index_in].dirty = 1'b0;
      end
      OpDirtySet:   entries_d[way_index_in].dirty = 1'b1;
      OpDirtyClear: entries_d[way_index_in].dirty = 1'b0;
      default: ;
    endcase
  end

`ifdef TAG_STORE_FWD_EN
  assign view = entries_d;
`else
  assign view = entries_q;
`endif

  always_comb begin
    view_tags  = '0;
    view_valid = '0;
    for (int i = 0; i < int'(NUM_WAYS); i++) begin
      view_tags[i]  = view[i].tag;
      view_valid[i] = view[i].valid;
    end
  end

  tag_match #(
    .TAG_WIDTH(TAG_WIDTH),
    .NUM_WAYS (NUM_WAYS)
  ) u_tag_match (
    .tags   (view_tags),
    .valid  (view_valid),
    .tag_in (tag_in),
    .match  (match_vec),
    .any_hit(any_hit),
    .hit_idx(match_idx)
  );

  // hit_way_index only moves on a lookup; a miss reports way 0.
  always_comb begin
    hit_d     = lookup_en && (|match_vec);
    hit_idx_d = hit_idx_q;
    if (lookup_en) begin
      hit_idx_d = any_hit ? match_idx : '0;
    end
  end

  always_comb begin
    valid_read_d = valid_read_q;
    dirty_read_d = dirty_read_q;
    tag_read_d   = tag_read_q;
    if (read_en) begin
      valid_read_d = view[way_index_in].valid;
      dirty_read_d = view[way_index_in].dirty;
      tag_read_d   = view[way_index_in].tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q    <= '0;
      hit_q        <= 1'b0;
      hit_idx_q    <= '0;
      valid_read_q <= 1'b0;
      dirty_read_q <= 1'b0;
      tag_read_q   <= '0;
    end else begin
      entries_q    <= entries_d;
      hit_q        <= hit_d;
      hit_idx_q    <= hit_idx_d;
      valid_read_q <= valid_read_d;
      dirty_read_q <= dirty_read_d;
      tag_read_q   <= tag_read_d;
    end
  end

  assign hit           = hit_q;
  assign hit_way_index = hit_idx_q;
  assign valid_read    = valid_read_q;
  assign dirty_read    = dirty_read_q;
  assign tag_read      = tag_read_q;

endmodule

// File: tb/tb_tag_store.sv
// Directed bench for tag_store: hand-computed expectations checked with immediate assertions.
module tb_tag_store;

  localparam int unsigned TW = 4;
  localparam int unsigned NW = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          write_en, read_en, lookup_en;
  logic [TW-1:0] tag_in;
  logic [IW-1:0] way_index_in;
  logic          valid_clear, dirty_set, dirty_clear;
  logic          hit;
  logic [IW-1:0] hit_way_index;
  logic          valid_read, dirty_read;
  logic [TW-1:0] tag_read;

  int checks = 0;
  int errors = 0;

  tag_store #(
    .TAG_WIDTH(TW),
    .NUM_WAYS (NW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .write_en     (write_en),
    .read_en      (read_en),
    .lookup_en    (lookup_en),
    .tag_in       (tag_in),
    .way_index_in (way_index_in),
    .valid_clear  (valid_clear),
    .dirty_set    (dirty_set),
    .dirty_clear  (dirty_clear),
    .hit          (hit),
    .hit_way_index(hit_way_index),
    .valid_read   (valid_read),
    .dirty_read   (dirty_read),
    .tag_read     (tag_read)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic idle();
    rst          = 1'b0;
    write_en     = 1'b0;
    read_en      = 1'b0;
    lookup_en    = 1'b0;
    valid_clear  = 1'b0;
    dirty_set    = 1'b0;
    dirty_clear  = 1'b0;
    tag_in       = '0;
    way_index_in = '0;
  endtask

  // Inputs change #1 after the edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [IW-1:0] way, input logic [TW-1:0] tag);
    idle(); write_en = 1'b1; way_index_in = way; tag_in = tag; tick();
  endtask

  task automatic rd(input logic [IW-1:0] way);
    idle(); read_en = 1'b1; way_index_in = way; tick();
  endtask

  task automatic lk(input logic [TW-1:0] tag);
    idle(); lookup_en = 1'b1; tag_in = tag; tick();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    #1;
    tick();
    tick();
    check("rst_hit", 32'(hit), 32'd0);
    check("rst_idx", 32'(hit_way_index), 32'd0);
    check("rst_valid", 32'(valid_read), 32'd0);
    check("rst_dirty", 32'(dirty_read), 32'd0);
    check("rst_tag", 32'(tag_read), 32'd0);

    wr(2'd0, 4'hA);
    wr(2'd1, 4'hB);
    wr(2'd2, 4'hC);

    rd(2'd0);
    check("rd0_tag", 32'(tag_read), 32'hA);
    check("rd0_valid", 32'(valid_read), 32'd1);
    check("rd0_dirty", 32'(dirty_read), 32'd0);
    rd(2'd1);
    check("rd1_tag", 32'(tag_read), 32'hB);
    rd(2'd2);
    check("rd2_tag", 32'(tag_read), 32'hC);
    check("rd2_valid", 32'(valid_read), 32'd1);
    idle(); tick();
    check("rd_hold_tag", 32'(tag_read), 32'hC);

    lk(4'hB);
    check("lk_b_hit", 32'(hit), 32'd1);
    check("lk_b_idx", 32'(hit_way_index), 32'd1);
    lk(4'hC);
    check("lk_c_hit", 32'(hit), 32'd1);
    check("lk_c_idx", 32'(hit_way_index), 32'd2);
    idle(); tick();
    check("lk_idle_hit", 32'(hit), 32'd0);
    check("lk_idle_idx_hold", 32'(hit_way_index), 32'd2);
    lk(4'hF);
    check("lk_f_hit", 32'(hit), 32'd0);
    check("lk_f_idx", 32'(hit_way_index), 32'd0);

    idle(); dirty_set = 1'b1; way_index_in = 2'd1; tick();
    rd(2'd1);
    check("dset_w1", 32'(dirty_read), 32'd1);
    idle(); dirty_clear = 1'b1; way_index_in = 2'd1; tick();
    rd(2'd1);
    check("dclr_w1", 32'(dirty_read), 32'd0);

    idle(); valid_clear = 1'b1; way_index_in = 2'd1; tick();
    rd(2'd1);
    check("vclr_valid", 32'(valid_read), 32'd0);
    check("vclr_tag_kept", 32'(tag_read), 32'hB);
    lk(4'hB);
    check("stale_no_hit", 32'(hit), 32'd0);

    // Dirty set applies even to an invalid way.
    idle(); dirty_set = 1'b1; way_index_in = 2'd1; tick();
    rd(2'd1);
    check("dset_invalid_dirty", 32'(dirty_read), 32'd1);
    check("dset_invalid_valid", 32'(valid_read), 32'd0);

    wr(2'd2, 4'h5);
    wr(2'd3, 4'h5);
    lk(4'h5);
    check("dup_hit", 32'(hit), 32'd1);
    check("dup_lowest", 32'(hit_way_index), 32'd2);

    // Write beats valid_clear and also clears a prior dirty bit.
    idle(); dirty_set = 1'b1; way_index_in = 2'd3; tick();
    idle(); write_en = 1'b1; valid_clear = 1'b1; way_index_in = 2'd3; tag_in = 4'h6; tick();
    rd(2'd3);
    check("wr_vs_vclr_valid", 32'(valid_read), 32'd1);
    check("wr_vs_vclr_dirty", 32'(dirty_read), 32'd0);
    check("wr_vs_vclr_tag", 32'(tag_read), 32'h6);

    idle(); dirty_set = 1'b1; dirty_clear = 1'b1; way_index_in = 2'd3; tick();
    rd(2'd3);
    check("dset_vs_dclr", 32'(dirty_read), 32'd1);

    idle(); valid_clear = 1'b1; dirty_set = 1'b1; way_index_in = 2'd3; tick();
    rd(2'd3);
    check("vclr_vs_dset_valid", 32'(valid_read), 32'd0);
    check("vclr_vs_dset_dirty", 32'(dirty_read), 32'd0);

    // Read of a way being written in the same cycle.
    idle(); write_en = 1'b1; read_en = 1'b1; way_index_in = 2'd0; tag_in = 4'h9; tick();
`ifdef TAG_STORE_FWD_EN
    check("same_cyc_rd_tag", 32'(tag_read), 32'h9);
`else
    check("same_cyc_rd_tag", 32'(tag_read), 32'hA);
`endif
    rd(2'd0);
    check("post_wr_rd_tag", 32'(tag_read), 32'h9);

    // Reset overrides a live lookup that would otherwise hit way 2.
    idle(); rst = 1'b1; lookup_en = 1'b1; tag_in = 4'h5; tick();
    check("mid_rst_hit", 32'(hit), 32'd0);
    check("mid_rst_idx", 32'(hit_way_index), 32'd0);
    for (int w = 0; w < int'(NW); w++) begin
      rd(IW'(w));
      check($sformatf("mid_rst_rd%0d_valid", w), 32'(valid_read), 32'd0);
      check($sformatf("mid_rst_rd%0d_tag", w), 32'(tag_read), 32'd0);
    end

    idle(); write_en = 1'b1; lookup_en = 1'b1; way_index_in = 2'd0; tag_in = 4'h7; tick();
`ifdef TAG_STORE_FWD_EN
    check("same_cyc_lk_hit", 32'(hit), 32'd1);
`else
    check("same_cyc_lk_hit", 32'(hit), 32'd0);
`endif
    check("same_cyc_lk_idx", 32'(hit_way_index), 32'd0);
    lk(4'h7);
    check("post_wr_lk_hit", 32'(hit), 32'd1);

    idle(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tag_store.md
Name: tag_store

Overview:
Fully associative tag/state array for the victim cache: NUM_WAYS entries, each holding tag, valid bit and dirty bit.
- Controller writes, reads, invalidates and marks entries dirty/clean by explicit way index.
- Parallel associative lookup returns hit and matching way.
- Sits beside the victim data array; victim controller drives all enables.

Parameters:
TAG_WIDTH, 4, width of stored and compared tag
NUM_WAYS, 4, number of entries; power of two, >=2; index width IW = $clog2(NUM_WAYS)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
write_en  input  1  write tag_in into way way_index_in
read_en  input  1  read entry way_index_in to tag_read/valid_read/dirty_read
lookup_en  input  1  associative search for tag_in
tag_in  input  TAG_WIDTH  tag for write/lookup
way_index_in  input  IW  target way for write/read/valid_clear/dirty_set/dirty_clear
valid_clear  input  1  invalidate way_index_in
dirty_set  input  1  set dirty of way_index_in
dirty_clear  input  1  clear dirty of way_index_in
hit  output  1  registered lookup result
hit_way_index  output  IW  registered matching way
valid_read  output  1  registered valid of read way
dirty_read  output  1  registered dirty of read way
tag_read  output  TAG_WIDTH  registered tag of read way

Behaviour:
- Reset (rst=1 at posedge): all valid=0, dirty=0, tags=0; hit=0, hit_way_index=0, valid_read=0, dirty_read=0, tag_read=0. Reset overrides all enables.
- All state updates occur at posedge clk; no combinational input-to-output paths.
- write_en: entry[way].tag<=tag_in, valid<=1, dirty<=0.
- valid_clear: entry[way].valid<=0 and dirty<=0; tag retained.
- dirty_set: entry[way].dirty<=1, applied regardless of valid.
- dirty_clear: entry[way].dirty<=0.
- Same-cycle priority on the shared way index: write_en > valid_clear > dirty_set > dirty_clear. Only the highest active op takes effect.
- read_en: tag/valid/dirty of entry[way_index_in] registered onto read outputs.
  - Latency 1: data visible the cycle after read_en.
  - Outputs hold their last value while read_en=0.
- lookup_en: compare tag_in with every entry where valid=1.
  - hit<=|match.
  - hit_way_index<=lowest matching index; 0 on miss.
  - Latency 1.
  - Cycle with lookup_en=0: hit<=0, hit_way_index holds.
- Read and lookup sample pre-update state when combined with a same-cycle write/clear/set, unless the optional feature is enabled.
- read_en, lookup_en and a modify op may all be asserted together; all act independently.
- Invalid entries never hit, even with a matching stale tag.
- Duplicate tags are permitted; lowest index wins.

Optional Feature:
Macro TAG_STORE_FWD_EN.
- Defined: same-cycle forwarding.
  - A read of the way being modified returns the post-update tag/valid/dirty.
  - A lookup sees the post-update array, e.g. a write of tag_in to a way hits that way, and a valid_clear suppresses a match.
- Undefined: read/lookup observe pre-update state.

Decomposition:
- Package tag_store_pkg:
  - typedef struct tag_entry_t {valid, dirty, tag[TAG_WIDTH-1:0]};
  - op-priority constants.
- One sub-module, tag_match: combinational comparator array plus lowest-index priority encoder producing match/any_hit/hit_idx.

Test Plan:
- Reset, then write way0=0xA, way1=0xB, way2=0xC; read ways 0,1,2 -> tag_read 0xA/0xB/0xC, valid_read=1, dirty_read=0, one cycle after each read_en.
- Lookup 0xB -> hit=1, hit_way_index=1; lookup 0xC -> hit=1, idx=2; lookup 0xF -> hit=0.
- dirty_set way1, read way1 -> dirty_read=1; dirty_clear way1, read way1 -> dirty_read=0.
- valid_clear way1, read way1 -> valid_read=0, tag_read=0xB; lookup 0xB -> hit=0.
- Write 0x5 to ways 2 and 3, lookup 0x5 -> hit_way_index=2. Simultaneous write_en+valid_clear on way3 -> way3 valid=1. dirty_set+dirty_clear -> dirty=1.
- Assert rst mid-sequence with lookup_en=1 -> next cycle hit=0, all reads return valid=0; with/without TAG_STORE_FWD_EN, same-cycle write 0x7 to way0 + lookup 0x7 -> hit=1 / hit=0.
